// File: rtl/dm_lsu_if.sv
// rtl/dm_lsu_if.sv - request/response and data-memory port bundle for dm_lsu
interface dm_lsu_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [31:0]       mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - byte/half/word load-store unit with sub-word read-modify-write
module dm_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  dm_lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_din;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_err;
  logic              w_word_store;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  assign w_accept     = bus.req_valid && (r_state == S_IDLE);
  assign w_word_store = bus.req_we && (bus.req_size == 2'b10);

  always_comb begin
    w_err = 1'b0;
    case (bus.req_size)
      2'b01:   w_err = bus.req_addr[0];
      2'b10:   w_err = (bus.req_addr[1:0] != 2'b00);
      2'b11:   w_err = 1'b1;
      default: w_err = 1'b0;
    endcase
  end

  // Load extension and store merge act on the word being captured at the end of RD.
  always_comb begin
    w_load = bus.mem_dout;
    case (r_size)
      2'b00:   w_load = {{24{r_signed & bus.mem_dout[7]}}, bus.mem_dout[7:0]};
      2'b01:   w_load = {{16{r_signed & bus.mem_dout[15]}}, bus.mem_dout[15:0]};
      default: w_load = bus.mem_dout;
    endcase
  end

  assign w_merge = (r_size == 2'b00) ? {bus.mem_dout[31:8],  r_wdata[7:0]}
                                     : {bus.mem_dout[31:16], r_wdata[15:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_err)             w_next = S_RESP;
          else if (w_word_store) w_next = S_WR;
          else                   w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= 32'h0;
      r_mem_addr <= '0;
      r_mem_din  <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_we     <= bus.req_we;
        r_wdata  <= bus.req_wdata;
        r_err    <= w_err;
        r_rdata  <= 32'h0;
        // Memory-side outputs only move when an access will actually happen.
        if (!w_err) begin
          r_mem_addr <= bus.req_addr;
          if (w_word_store) r_mem_din <= bus.req_wdata;
        end
      end
      if (r_state == S_RD) begin
        if (r_we) r_mem_din <= w_merge;
        else      r_rdata   <= w_load;
      end
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_din    = r_mem_din;
  assign bus.mem_we     = (r_state == S_WR);

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - randomized self-checking bench for dm_lsu against a byte-array model
module tb_dm_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dm_lsu_if #(.ADDR_W(10)) bus ();

  dm_lsu #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory behaving as dm_1k; ref_mem is the reference model's own view.
  bit [7:0] mem     [1024];
  bit [7:0] ref_mem [1024];

  always_comb begin
    bus.mem_dout = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (int'(bus.mem_addr) + i < 1024)
        bus.mem_dout[8*i +: 8] = mem[int'(bus.mem_addr) + i];
    end
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (int'(bus.mem_addr) + i < 1024)
          mem[int'(bus.mem_addr) + i] <= bus.mem_din[8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int addr);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++)
      if (addr + i < 1024) w[8*i +: 8] = ref_mem[addr + i];
    return w;
  endfunction

  task automatic scramble_req();
    bus.req_we     = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = 10'($urandom);
    bus.req_wdata  = $urandom;
  endtask

  task automatic op(input logic we, input logic [1:0] size, input logic sgn,
                    input int addr, input logic [31:0] wdata, output logic [31:0] rdata);
    logic        exp_err;
    int          nbytes;
    logic [31:0] ow;
    logic [31:0] exp_rdata;
    logic [31:0] exp_din;
    int          exp_lat;
    int          exp_we;
    int          lat;
    int          wecnt;
    bit          got;

    exp_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    ow      = ref_word(addr);
    exp_lat = exp_err ? 1 : (!we || size == 2'd2) ? 2 : 3;
    exp_we  = (!exp_err && we) ? 1 : 0;

    exp_rdata = 32'h0;
    if (!exp_err && !we) begin
      if (nbytes == 1) begin
        exp_rdata = ow & 32'hFF;
        if (sgn && ow[7]) exp_rdata = exp_rdata | 32'hFFFF_FF00;
      end else if (nbytes == 2) begin
        exp_rdata = ow & 32'hFFFF;
        if (sgn && ow[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
      end else begin
        exp_rdata = ow;
      end
    end
    exp_din = ow;
    for (int i = 0; i < nbytes; i++) exp_din[8*i +: 8] = wdata[8*i +: 8];

    @(negedge clk);
    chk("ready_before_req", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = 10'(addr);
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble_req();

    lat   = 0;
    wecnt = 0;
    got   = 1'b0;
    rdata = 32'h0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.mem_we) begin
        wecnt++;
        chk("wr_din", bus.mem_din, exp_din);
        chk("wr_addr", {22'b0, bus.mem_addr}, 32'(addr));
      end
      if (bus.resp_valid) begin
        got   = 1'b1;
        rdata = bus.resp_rdata;
        chk("resp_rdata", bus.resp_rdata, exp_rdata);
        chk("resp_err", {31'b0, bus.resp_err}, {31'b0, exp_err});
      end
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    chk("we_cycles", 32'(wecnt), 32'(exp_we));

    if (we && !exp_err)
      for (int i = 0; i < nbytes; i++)
        if (addr + i < 1024) ref_mem[addr + i] = wdata[8*i +: 8];
  endtask

  logic [31:0] rd;
  int          viol;

  initial begin
    bus.req_valid = 1'b0;
    scramble_req();

    #3;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {22'b0, bus.mem_addr}, 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(1'b1, 2'd2, 1'b0, 0, 32'h1234_5678, rd);
    op(1'b0, 2'd2, 1'b0, 0, 32'h0, rd);
    chk("lw0", rd, 32'h1234_5678);
    op(1'b0, 2'd0, 1'b1, 3, 32'h0, rd);
    chk("lb3", rd, 32'h0000_0012);
    op(1'b1, 2'd0, 1'b0, 2, 32'h0000_0080, rd);
    op(1'b0, 2'd0, 1'b1, 2, 32'h0, rd);
    chk("lb2", rd, 32'hFFFF_FF80);
    op(1'b0, 2'd0, 1'b0, 2, 32'h0, rd);
    chk("lbu2", rd, 32'h0000_0080);

    op(1'b1, 2'd2, 1'b0, 4, 32'hAABB_CCDD, rd);
    op(1'b1, 2'd2, 1'b0, 8, 32'h1122_3344, rd);
    op(1'b1, 2'd1, 1'b0, 4, 32'h0000_1234, rd);
    op(1'b0, 2'd2, 1'b0, 4, 32'h0, rd);
    chk("lw4_after_sh", rd, 32'hAABB_1234);
    op(1'b0, 2'd2, 1'b0, 8, 32'h0, rd);
    chk("lw8_untouched", rd, 32'h1122_3344);

    op(1'b0, 2'd1, 1'b0, 1, 32'h0, rd);
    op(1'b1, 2'd2, 1'b0, 2, 32'hDEAD_BEEF, rd);
    op(1'b0, 2'd3, 1'b0, 0, 32'h0, rd);
    op(1'b1, 2'd3, 1'b0, 12, 32'hFFFF_FFFF, rd);

    op(1'b1, 2'd0, 1'b0, 1023, 32'h0000_005A, rd);
    op(1'b0, 2'd0, 1'b0, 1023, 32'h0, rd);
    chk("lbu1023", rd, 32'h0000_005A);
    op(1'b0, 2'd2, 1'b0, 1020, 32'h0, rd);
    chk("lw1020_top", {24'b0, rd[31:24]}, 32'h0000_005A);

    // Reset dropped during the RD cycle of a byte store.
    op(1'b1, 2'd2, 1'b0, 500, 32'hC3C3_C3C3, rd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 10'd501;
    bus.req_wdata  = 32'h0000_0011;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("midrst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("midrst_mem_addr", {22'b0, bus.mem_addr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_we || !bus.req_ready) viol++;
    end
    chk("midrst_quiet", 32'(viol), 32'd0);
    op(1'b0, 2'd2, 1'b0, 500, 32'h0, rd);
    chk("midrst_mem_unchanged", rd, 32'hC3C3_C3C3);

    for (int n = 0; n < 300; n++) begin
      int          r;
      logic [1:0]  sz;
      int          a;
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~1;
        if (sz == 2'd2) a = a & ~3;
      end
      op(1'($urandom), sz, 1'($urandom), a, $urandom, rd);
    end

    @(negedge clk);
    viol = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] != ref_mem[i]) viol++;
    chk("final_memory_bytes_differing", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store unit that sits between the CPU's memory stage and the 1 KiB byte-addressed data memory `dm_1k`, acting as the initiator that drives that memory's `addr`/`din`/`WriteEn` port. It accepts one byte, halfword or word load/store request at a time over a valid/ready handshake. It performs sign or zero extension on loads and read-modify-write merging for sub-word stores. It returns a single-cycle response with data and an error flag.

## Interface
- `ADDR_W`, default 10: byte-address width; memory size is 2^ADDR_W bytes.
- `clk`, input, 1: single clock, all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: unit idle and able to accept; a request transfers on a rising edge where `req_valid && req_ready`.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_size`, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed`, input, 1: sign-extend loads; ignored for stores and word loads.
- `req_addr`, input, ADDR_W: byte address.
- `req_wdata`, input, 32: store data, low-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`, output, 1: one-cycle completion pulse.
- `resp_rdata`, output, 32: load result; 0 for stores and errors.
- `resp_err`, output, 1: valid with `resp_valid`; misaligned access or illegal size.
- `mem_addr`, output, ADDR_W: to `dm_1k.addr`.
- `mem_din`, output, 32: to `dm_1k.din`.
- `mem_we`, output, 1: to `dm_1k.WriteEn`.
- `mem_dout`, input, 32: from `dm_1k.dout`.

## Operation
- Memory contract:
  - `mem_dout` is a combinational little-endian read of bytes `mem_addr..mem_addr+3`, with the byte at `mem_addr` in bits [7:0]. Bytes beyond the top of memory read as 0.
  - When `mem_we` is high at a rising edge, the memory writes all four bytes of `mem_din` at `mem_addr..+3`. Bytes beyond the top are dropped.
- States are IDLE, RD, WR and RESP. `req_ready` = (state == IDLE).
- On acceptance, the unit latches `req_addr`, `req_size`, `req_signed`, `req_we` and `req_wdata`.
- Error check at acceptance:
  - Illegal size: `req_size` == 11.
  - Misaligned halfword: `addr[0]` set.
  - Misaligned word: `addr[1:0]` nonzero.
  - On error: IDLE -> RESP with `resp_err` = 1. No memory access occurs; `mem_we` stays 0.
- Transitions:
  - Load: IDLE -> RD -> RESP.
  - Word store: IDLE -> WR -> RESP.
  - Byte/half store: IDLE -> RD -> WR -> RESP.
  - RESP -> IDLE unconditionally.
- RD:
  - `mem_addr` = latched address and `mem_we` = 0.
  - At the end of the cycle, `mem_dout` is captured into a 32-bit read buffer.
- Load result, built from the read buffer:
  - Byte: [7:0], extended with bit 7 if signed, else zero.
  - Half: [15:0], extended with bit 15 if signed, else zero.
  - Word: unchanged.
- WR:
  - `mem_we` = 1 and `mem_addr` = latched address.
  - `mem_din` for word stores = wdata.
  - `mem_din` for half stores = {buf[31:16], wdata[15:0]}.
  - `mem_din` for byte stores = {buf[31:8], wdata[7:0]}.
  - Upper bytes are thus preserved, including bytes outside the addressed unit.
- RESP: `resp_valid` = 1; `resp_rdata` and `resp_err` are registered outputs, valid only in this cycle.
- `mem_addr` and `mem_din` hold their last values outside RD/WR; `mem_we` is 0 everywhere except WR.

## Timing
- Reset values, asserted immediately while `rst_n` = 0:
  - State IDLE, so `req_ready` = 1.
  - `resp_valid`, `resp_err` and `mem_we` = 0.
  - `resp_rdata`, `mem_addr`, `mem_din` and the read buffer = 0.
- Counting from the acceptance edge E, `resp_valid` is high in the cycle after:
  - Error: edge E.
  - Load or word store: edge E+1.
  - Sub-word store: edge E+2.
- For sub-word stores, the memory write commits at edge E+2.
- Throughput: no new request is accepted until the cycle after RESP. Back-to-back requests are separated by at least one idle cycle.
- `req_*` inputs are sampled only at acceptance; later changes have no effect.
- Reset mid-operation: an asynchronous `rst_n` drop in RD or WR forces IDLE and drops `mem_we` immediately. The in-flight request is discarded with no response, and no partial write commits.
- `req_valid` in a non-IDLE state is ignored; the requester must hold it until `req_ready`.

## Test plan
- Word store then word load: sw 0x12345678 @0, then lw @0 -> `mem_we` high exactly one cycle. Load response arrives 2 cycles after acceptance with `resp_rdata` 0x12345678 and `resp_err` 0.
- Signed and unsigned byte loads: memory[0..3] = 0x12345678; lb @3 -> 0x00000012; store 0x80 via sb @2, then lb @2 -> 0xFFFFFF80 and lbu @2 -> 0x00000080.
- Sub-word store read-modify-write: memory word @4 = 0xAABBCCDD; sh 0x1234 @4 -> `mem_din` 0xAABB1234 in WR. A following lw @4 returns 0xAABB1234, and bytes 8..10 are unchanged.
- Misalignment and illegal size:
  - lh @1 -> `resp_err` 1, `resp_rdata` 0, one cycle after acceptance.
  - sw @2 -> `resp_err` 1, `mem_we` never asserted.
  - size 11 -> `resp_err` 1.
- Top of memory: sb 0x5A @1023, then lbu @1023 -> 0x0000005A. lw @1020 after that store returns 0x5A in [31:24].
- Reset mid-operation: pull `rst_n` low during the RD cycle of an sb -> `mem_we` stays 0, no `resp_valid`, `req_ready` = 1 after release, and memory is unchanged.
